// File: rtl/pam_sampler.sv
// pam_sampler: pulse-amplitude-modulation sampler with flat-top or natural sampling
module pam_sampler #(
    parameter int PERIOD  = 16,
    parameter int PULSE_W = 4,
    parameter int NATURAL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] sine_in,
    output logic [15:0] pam_out,
    output logic        pulse,
    output logic        sample_stb,
    output logic [7:0]  sample_cnt
);
    localparam int PW = $clog2(PERIOD);
    if (PERIOD < 2 || PULSE_W < 1 || PULSE_W >= PERIOD) begin : g_bad_params
        $error("pam_sampler: need PERIOD>=2 and 1<=PULSE_W<PERIOD");
    end
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
    state_t        r_state;
    logic [PW-1:0] r_ph;
    logic [15:0]   r_hold;
    logic [15:0]   r_pam;
    logic          r_pulse;
    logic          r_stb;
    logic [7:0]    r_cnt;
    logic          w_capture;
    assign w_capture  = r_state == IDLE || (r_state == GAP && r_ph == PW'(PERIOD - 1));
    assign pam_out    = r_pam;
    assign pulse      = r_pulse;
    assign sample_stb = r_stb;
    assign sample_cnt = r_cnt;
    // sampling FSM: capture, hold the pulse for PULSE_W cycles, then idle out the rest of the period
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ph    <= '0;
            r_hold  <= '0;
            r_pam   <= '0;
            r_pulse <= 1'b0;
            r_stb   <= 1'b0;
            r_cnt   <= '0;
        end else if (!en) begin
            r_state <= IDLE;
            r_ph    <= '0;
            r_pam   <= '0;
            r_pulse <= 1'b0;
            r_stb   <= 1'b0;
        end else if (w_capture) begin
            r_state <= PULSE;
            r_ph    <= '0;
            r_hold  <= sine_in;
            r_pam   <= sine_in;
            r_pulse <= 1'b1;
            r_stb   <= 1'b1;
            r_cnt   <= r_cnt + 8'd1;
        end else if (r_state == PULSE) begin
            r_stb <= 1'b0;
            r_ph  <= r_ph + PW'(1);
            if (r_ph == PW'(PULSE_W - 1)) begin
                r_state <= GAP;
                r_pam   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_pam <= (NATURAL != 0) ? sine_in : r_hold;
            end
        end else begin
            r_stb <= 1'b0;
            r_ph  <= r_ph + PW'(1);
        end
    end
endmodule

// File: tb/tb_pam_sampler.sv
// tb_pam_sampler: randomized and directed checks of pam_sampler against a behavioural model
module tb_pam_sampler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] sine_in = '0;
    logic [15:0] d_pam [3];
    logic        d_pulse [3];
    logic        d_stb [3];
    logic [7:0]  d_cnt [3];

    int          n_chk = 0;
    int          n_pass = 0;
    int          age [3] = '{-1, -1, -1};
    int          caps [3] = '{0, 0, 0};
    logic [15:0] hold [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] m_pam [3];
    logic        m_pulse [3];
    logic        m_stb [3];
    logic [7:0]  m_cnt [3];
    bit          wrap_seen = 1'b0;
    logic [3:0]  seq = 4'b0101;

    always #5 clk = ~clk;

    pam_sampler #(.PERIOD(16), .PULSE_W(4), .NATURAL(0)) u_flat (
        .clk(clk), .rst(rst), .en(en), .sine_in(sine_in),
        .pam_out(d_pam[0]), .pulse(d_pulse[0]), .sample_stb(d_stb[0]), .sample_cnt(d_cnt[0]));
    pam_sampler #(.PERIOD(16), .PULSE_W(4), .NATURAL(1)) u_nat (
        .clk(clk), .rst(rst), .en(en), .sine_in(sine_in),
        .pam_out(d_pam[1]), .pulse(d_pulse[1]), .sample_stb(d_stb[1]), .sample_cnt(d_cnt[1]));
    pam_sampler #(.PERIOD(2), .PULSE_W(1), .NATURAL(0)) u_min (
        .clk(clk), .rst(rst), .en(en), .sine_in(sine_in),
        .pam_out(d_pam[2]), .pulse(d_pulse[2]), .sample_stb(d_stb[2]), .sample_cnt(d_cnt[2]));

    function automatic int per(int k);
        return (k == 2) ? 2 : 16;
    endfunction

    function automatic int wid(int k);
        return (k == 2) ? 1 : 4;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s[%0d] t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
        else
            n_pass++;
    endtask

    // age = cycles since the last capture, -1 when not sampling
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                age[k]  = -1;
                hold[k] = '0;
                caps[k] = 0;
            end else if (!en) begin
                age[k] = -1;
            end else if (age[k] < 0 || age[k] == per(k) - 1) begin
                age[k]  = 0;
                hold[k] = sine_in;
                caps[k]++;
            end else begin
                age[k]++;
            end
            m_pulse[k] = age[k] >= 0 && age[k] < wid(k);
            m_stb[k]   = age[k] == 0;
            m_pam[k]   = !m_pulse[k] ? 16'h0 : (k == 1) ? sine_in : hold[k];
            m_cnt[k]   = 8'(caps[k] % 256);
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("pam_out", k, 32'(d_pam[k]), 32'(m_pam[k]));
            chk("pulse", k, 32'(d_pulse[k]), 32'(m_pulse[k]));
            chk("sample_stb", k, 32'(d_stb[k]), 32'(m_stb[k]));
            chk("sample_cnt", k, 32'(d_cnt[k]), 32'(m_cnt[k]));
        end
    endtask

    task automatic wait_stb(int k);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!d_stb[k] && n < 64);
        chk("stb_wait", k, 32'(d_stb[k]), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pam", 0, 32'(d_pam[0]), 32'h0);
        chk("rst_cnt", 0, 32'(d_cnt[0]), 32'h0);
        chk("rst_pulse", 2, 32'(d_pulse[2]), 32'h0);
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sine_in = 16'(i);
            tick();
            if (i < 20) begin
                chk("ramp_pam", 0, 32'(d_pam[0]), (i >= 16) ? 32'h10 : 32'h0);
                chk("ramp_pulse", 0, 32'(d_pulse[0]), (i < 4 || i >= 16) ? 32'd1 : 32'd0);
                chk("ramp_stb", 0, 32'(d_stb[0]), (i == 0 || i == 16) ? 32'd1 : 32'd0);
            end
            if (i < 16)
                chk("ramp_nat", 1, 32'(d_pam[1]), (i < 4) ? 32'(i) : 32'h0);
        end
        wait_stb(0);
        tick();
        tick();
        en = 1'b0;
        tick();
        chk("abort_pam", 0, 32'(d_pam[0]), 32'h0);
        chk("abort_pulse", 0, 32'(d_pulse[0]), 32'h0);
        repeat (4) tick();
        en      = 1'b1;
        sine_in = 16'h1234;
        tick();
        chk("restart_stb", 0, 32'(d_stb[0]), 32'd1);
        chk("restart_pam", 0, 32'(d_pam[0]), 32'h1234);
        wait_stb(0);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk("midgap_cnt", 0, 32'(d_cnt[0]), 32'h0);
        chk("midgap_pam", 0, 32'(d_pam[0]), 32'h0);
        chk("midgap_stb", 0, 32'(d_stb[0]), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_stb", 0, 32'(d_stb[0]), 32'd1);
        chk("post_rst_cnt", 0, 32'(d_cnt[0]), 32'd1);
        for (int i = 0; i < 300; i++) begin
            en      = $urandom_range(0, 9) != 0;
            rst     = $urandom_range(0, 99) == 0;
            sine_in = 16'($urandom);
            tick();
        end
        rst = 1'b1;
        en  = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4200; i++) begin
            sine_in = 16'($urandom);
            tick();
            if (!wrap_seen && caps[0] == 256 && d_stb[0]) begin
                chk("wrap_cnt", 0, 32'(d_cnt[0]), 32'h0);
                wrap_seen = 1'b1;
            end
        end
        chk("wrap_seen", 0, 32'(wrap_seen), 32'd1);
        sine_in = 16'hFFFF;
        wait_stb(0);
        chk("full_scale", 0, 32'(d_pam[0]), 32'hFFFF);
        wait_stb(2);
        for (int i = 0; i < 4; i++) begin
            chk("min_pulse", 2, 32'(d_pulse[2]), 32'(seq[i]));
            chk("min_stb", 2, 32'(d_stb[2]), 32'(seq[i]));
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
